uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART RX data stage. It captures each received byte on its one-cycle valid strobe, drops bytes flagged with a framing error, and queues good bytes in a circular FIFO. It presents them to the consumer through a registered pop interface, with occupancy, overflow and error-count status.

Parameters:
DATA_W, 8, width of one received character
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock; the only clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  DATA_W  received byte from the RX stage; valid only while rx_valid=1
rx_valid  input  1  one-clk pulse marking a completed frame (clk domain)
rx_frame_err  input  1  qualifies rx_valid: stop bit was 0
rd_en  input  1  pop request from consumer
rd_data  output  DATA_W  popped byte
rd_valid  output  1  one-clk pulse: rd_data updated
count  output  ADDR_W+1  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: a good byte was dropped because the FIFO was full
frame_err_cnt  output  8  saturating count of frames dropped for framing error
clr_flags  input  1  synchronous clear of overflow and frame_err_cnt

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - rd_data=0, rd_valid=0, overflow=0, frame_err_cnt=0.
  - Reset asserted mid-operation discards all stored data immediately. Memory contents need not be cleared.
- Write:
  - Accepted when rx_valid=1, rx_frame_err=0, and (full=0, or a pop occurs in the same cycle).
  - mem[wr_ptr] <= rx_data; wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- Framing-error drop:
  - rx_valid=1 with rx_frame_err=1: byte is never stored.
  - frame_err_cnt increments, saturating at 255.
- Overflow drop:
  - Good byte with full=1 and no pop that cycle: byte dropped, overflow <= 1, FIFO unchanged.
- Pop:
  - Occurs when rd_en=1 and empty=0.
  - Next cycle: rd_data = mem[rd_ptr as of the rd_en cycle], rd_valid=1 for exactly one clk.
  - rd_ptr increments modulo DEPTH. Latency is 1 clk from rd_en to data.
  - rd_en while empty: ignored, rd_valid stays 0, rd_data holds its previous value.
- rd_data holds its value between pops.
- count update per cycle: +1 on write only, -1 on pop only, unchanged on both or neither.
- empty and full are derived from the registered count, with no combinational path from inputs.
- Simultaneous events:
  - Push and pop when full: both succeed, count stays DEPTH, overflow not set.
  - Push and pop when empty: pop ignored, push succeeds, count becomes 1.
  - clr_flags in the same cycle as a new overflow or framing error: the new event wins (overflow=1, or frame_err_cnt=1).
- The block never stalls the RX stage; there is no backpressure output.

Test Plan:
- Reset, then push 0x42, 0xC3, 0x00 (3 good pulses), then rd_en three times -> rd_valid pulses one clk after each rd_en with data 0x42, 0xC3, 0x00 in order; count 3→0; empty=1 at end.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0xAA -> full=1, count=16, overflow=1. The following 16 pops return 0x00..0x0F, and 0xAA never appears.
- While full, push 0x55 with rd_en in the same cycle -> pop returns the oldest byte, count stays 16, overflow stays 0. The last byte popped after a full drain is 0x55.
- Three rx_valid pulses with rx_frame_err=1 -> frame_err_cnt=3, count=0. Then 300 error pulses -> frame_err_cnt=255. clr_flags coinciding with an error pulse -> frame_err_cnt=1.
- Push 10 bytes, pop 10 bytes, repeated 3 times (pointer wrap) -> data order preserved across the wrap, count returns to 0.
- Push 5 bytes, assert rst_n=0 for a fraction of a clk between edges -> count, pointers and flags clear immediately. After release, rd_en produces no rd_valid and empty=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART RX stage.
// Drops framing-error bytes and reports overflow and error counts.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        frame_err_cnt,
  input  logic              clr_flags
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              good;
  logic              pop;
  logic              push;
  logic              ovf_evt;
  logic              ferr_evt;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH[ADDR_W:0]);
  assign good     = rx_valid && !rx_frame_err;
  assign pop      = rd_en && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push     = good && (!full || pop);
  assign ovf_evt  = good && full && !pop;
  assign ferr_evt = rx_valid && rx_frame_err;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A new event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      if (ovf_evt)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (ferr_evt) begin
        if (clr_flags)                  frame_err_cnt <= 8'd1;
        else if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 1'b1;
      end else if (clr_flags) begin
        frame_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Directed stimulus queues expected bytes; a monitor checks each pop.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [7:0] frame_err_cnt;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb [$];

  uart_rx_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .frame_err_cnt(frame_err_cnt),
    .clr_flags    (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pop: got %0h expected none", rd_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (rd_data === e) passed++;
        else $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit acc);
    rx_data  = d;
    rx_valid = 1'b1;
    if (acc) sb.push_back(d);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pop(input bit exp);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("rd_valid_latency", rd_valid, exp);
  endtask

  task automatic push_pop(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    rd_en    = 1'b1;
    sb.push_back(d);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic ferr(input bit clr);
    rx_valid     = 1'b1;
    rx_frame_err = 1'b1;
    clr_flags    = clr;
    @(posedge clk); #1;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    clr_flags    = 1'b0;
  endtask

  task automatic clr();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ferr_cnt", frame_err_cnt, 0);
    rst_n = 1'b1;
    idle(1);

    push(8'h42, 1); push(8'hC3, 1); push(8'h00, 1);
    check("t1_count3", count, 3);
    check("t1_not_empty", empty, 0);
    pop(1); pop(1); pop(1);
    idle(1);
    check("t1_count0", count, 0);
    check("t1_empty", empty, 1);

    for (int i = 0; i < 16; i++) push(8'(i), 1);
    check("t2_full", full, 1);
    check("t2_count16", count, 16);
    check("t2_no_ovf_yet", overflow, 0);
    push(8'hAA, 0);
    check("t2_overflow", overflow, 1);
    check("t2_count_hold", count, 16);
    for (int i = 0; i < 16; i++) pop(1);
    idle(1);
    check("t2_drained", empty, 1);
    clr();
    check("t2_clr_ovf", overflow, 0);

    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1);
    push_pop(8'h55);
    check("t3_count16", count, 16);
    check("t3_no_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) pop(1);
    idle(1);
    check("t3_last_55", rd_data, 8'h55);
    check("t3_empty", empty, 1);

    ferr(0); ferr(0); ferr(0);
    check("t4_ferr3", frame_err_cnt, 3);
    check("t4_count0", count, 0);
    for (int i = 0; i < 300; i++) ferr(0);
    check("t4_ferr_sat", frame_err_cnt, 255);
    ferr(1);
    check("t4_clr_vs_err", frame_err_cnt, 1);
    clr();
    check("t4_clr", frame_err_cnt, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) push(8'(r * 16 + i), 1);
      check("t5_count10", count, 10);
      for (int i = 0; i < 10; i++) pop(1);
    end
    idle(3);
    check("t5_count0", count, 0);
    check("t5_rd_data_hold", rd_data, 8'h29);

    for (int i = 0; i < 5; i++) push(8'(8'hE0 + i), 0);
    ferr(0);
    check("t6_count5", count, 5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_empty", empty, 1);
    check("t6_async_ferr", frame_err_cnt, 0);
    #2 rst_n = 1'b1;
    idle(1);
    pop(0);
    check("t6_empty", empty, 1);
    idle(2);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
